// File: rtl/atan_arbiter.sv
// rtl/atan_arbiter.sv - shares one Arctan2 core between N_REQ requesters
//
// Grants one requester at a time, latches its operands into the core, runs the
// core until a rising edge of core_ready (or a timeout), and returns the angle
// with a one-cycle done pulse to the served requester. Dropping req mid-run
// aborts the service without a done. All outputs are registered.
//
// Optional build macro: ATAN_ARB_RR_EN selects round-robin arbitration
// (search starts at rr_ptr); when undefined the lowest requesting index wins.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   req[N_REQ]            level request per requester, held until done
//   arg1_flat, arg2_flat  per-requester operands, requester i at [i*DATA_W +: DATA_W]
//   grant[N_REQ]          one-hot requester being served
//   done[N_REQ]           one-cycle pulse, result valid
//   result[ANGLE_W]       signed angle, held until the next done
//   timeout_err           high with done when the service timed out
//   busy                  high whenever not idle
//   core_arg1, core_arg2  latched operands to the core
//   core_enable           core enable
//   core_reset            core reset
//   core_angle            core result
//   core_ready            core DataReady level
module atan_arbiter #(
  parameter int N_REQ          = 3,
  parameter int DATA_W         = 64,
  parameter int ANGLE_W        = 13,
  parameter int TIMEOUT_CYCLES = 512
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   arg1_flat,
  input  logic [N_REQ*DATA_W-1:0]   arg2_flat,
  output logic [N_REQ-1:0]          grant,
  output logic [N_REQ-1:0]          done,
  output logic [ANGLE_W-1:0]        result,
  output logic                      timeout_err,
  output logic                      busy,
  output logic [DATA_W-1:0]         core_arg1,
  output logic [DATA_W-1:0]         core_arg2,
  output logic                      core_enable,
  output logic                      core_reset,
  input  logic [ANGLE_W-1:0]        core_angle,
  input  logic                      core_ready
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic [N_REQ-1:0]   grant_d, done_d;
  logic [ANGLE_W-1:0] result_d;
  logic               terr_d, busy_d, en_d, crst_d;
  logic [DATA_W-1:0]  arg1_d, arg2_d;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;

`ifdef ATAN_ARB_RR_EN
  logic [IDX_W-1:0]   rr_ptr, rr_d;
  logic [IDX_W:0]     cand;

  // Scan from the highest offset down so the smallest offset from rr_ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_REQ)) cand = cand - (IDX_W+1)'(N_REQ);
      if (req[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end
`else
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(k);
      end
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    grant_d  = grant;
    done_d   = '0;
    result_d = result;
    terr_d   = 1'b0;
    busy_d   = busy;
    arg1_d   = core_arg1;
    arg2_d   = core_arg2;
    en_d     = core_enable;
    crst_d   = core_reset;
`ifdef ATAN_ARB_RR_EN
    rr_d     = rr_ptr;
`endif
    case (state_q)
      S_IDLE: begin
        en_d    = 1'b0;
        crst_d  = 1'b1;
        ready_d = 1'b0;
        busy_d  = 1'b0;
        grant_d = '0;
        if (win_found) begin
          win_d   = win_idx;
          grant_d = N_REQ'(1) << win_idx;
          arg1_d  = arg1_flat[win_idx*DATA_W +: DATA_W];
          arg2_d  = arg2_flat[win_idx*DATA_W +: DATA_W];
          busy_d  = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        // Core held in reset this cycle; ready_q follows core_ready from here so
        // a level left high across the reset is not taken as completion.
        en_d    = 1'b1;
        crst_d  = 1'b0;
        cnt_d   = '0;
        ready_d = core_ready;
        state_d = S_RUN;
      end
      S_RUN: begin
        ready_d = core_ready;
        if (!req[win_q]) begin
          grant_d = '0;
          busy_d  = 1'b0;
          en_d    = 1'b0;
          crst_d  = 1'b1;
          state_d = S_IDLE;
        end else if (core_ready && !ready_q) begin
          result_d = core_angle;
          done_d   = grant;
          en_d     = 1'b0;
          crst_d   = 1'b1;
          state_d  = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          result_d = '0;
          terr_d   = 1'b1;
          done_d   = grant;
          en_d     = 1'b0;
          crst_d   = 1'b1;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
`ifdef ATAN_ARB_RR_EN
        rr_d    = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      win_q       <= '0;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      grant       <= '0;
      done        <= '0;
      result      <= '0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      core_arg1   <= '0;
      core_arg2   <= '0;
      core_enable <= 1'b0;
      core_reset  <= 1'b1;
`ifdef ATAN_ARB_RR_EN
      rr_ptr      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      grant       <= grant_d;
      done        <= done_d;
      result      <= result_d;
      timeout_err <= terr_d;
      busy        <= busy_d;
      core_arg1   <= arg1_d;
      core_arg2   <= arg2_d;
      core_enable <= en_d;
      core_reset  <= crst_d;
`ifdef ATAN_ARB_RR_EN
      rr_ptr      <= rr_d;
`endif
    end
  end

endmodule

// File: tb/tb_atan_arbiter.sv
// tb/tb_atan_arbiter.sv - self-checking bench for atan_arbiter
module tb_atan_arbiter;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    req;
  logic [191:0]  arg1_flat, arg2_flat;
  logic [2:0]    grant, done;
  logic [12:0]   result;
  logic          timeout_err, busy;
  logic [63:0]   core_arg1, core_arg2;
  logic          core_enable, core_reset;
  logic [12:0]   core_angle;
  logic          core_ready;

  int checks = 0;
  int failures = 0;
  bit never_ready = 1'b0;

  atan_arbiter dut (
    .clk(clk), .reset(reset), .req(req),
    .arg1_flat(arg1_flat), .arg2_flat(arg2_flat),
    .grant(grant), .done(done), .result(result),
    .timeout_err(timeout_err), .busy(busy),
    .core_arg1(core_arg1), .core_arg2(core_arg2),
    .core_enable(core_enable), .core_reset(core_reset),
    .core_angle(core_angle), .core_ready(core_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [2:0] r, input int p);
`ifdef ATAN_ARB_RR_EN
    for (int k = 0; k < 3; k++) if (r[(p + k) % 3]) return (p + k) % 3;
`else
    for (int k = 0; k < 3; k++) if (r[k]) return k;
`endif
    return -1;
  endfunction

  // Core model: ready rises once 40 enabled cycles have elapsed; the angle
  // is derived from the operand the core actually received.
  int core_cnt;
  initial begin
    core_ready = 1'b0;
    core_angle = '0;
    core_cnt   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (core_reset) begin
        core_cnt   = 0;
        core_ready = 1'b0;
      end else if (core_enable) begin
        core_cnt++;
        if (core_cnt >= 40 && !never_ready) begin
          core_ready = 1'b1;
          core_angle = 13'(100 * (int'(core_arg1[7:0]) + 1));
        end
      end
    end
  end

  // Inputs as seen by the DUT at each active edge.
  logic          rst_s = 1'b1;
  logic [2:0]    req_s;
  logic [191:0]  a1_s, a2_s;
  initial forever begin
    @(posedge clk);
    rst_s = reset;
    req_s = req;
    a1_s  = arg1_flat;
    a2_s  = arg2_flat;
  end

  // Transaction-level model and per-cycle compare.
  int          served[$];
  initial begin
    int          cyc, gcyc, w_m, rr_m;
    logic [63:0] e_a1, e_a2;
    logic [12:0] e_res;
    logic [2:0]  prev_grant;
    cyc = 0; gcyc = 0; w_m = 0; rr_m = 0;
    e_a1 = '0; e_a2 = '0; e_res = '0; prev_grant = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_s) begin
        check("rst_grant", 64'(grant), 0);
        check("rst_done", 64'(done), 0);
        check("rst_result", 64'(result), 0);
        check("rst_terr", 64'(timeout_err), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_core_en", 64'(core_enable), 0);
        check("rst_core_rst", 64'(core_reset), 1);
        check("rst_arg1", core_arg1, 0);
        check("rst_arg2", core_arg2, 0);
        e_res = '0;
        rr_m = 0;
        prev_grant = '0;
      end else begin
        if (prev_grant == 3'b0 && grant != 3'b0) begin
          w_m = pick(req_s, rr_m);
          check("grant_winner", 64'(grant), (w_m < 0) ? 64'd0 : 64'(3'b001 << w_m));
          if (w_m < 0) w_m = 0;
          e_a1 = a1_s[w_m*64 +: 64];
          e_a2 = a2_s[w_m*64 +: 64];
          gcyc = cyc;
        end else if (prev_grant != 3'b0 && grant != 3'b0) begin
          check("grant_stable", 64'(grant), 64'(prev_grant));
        end
        if (grant != 3'b0) begin
          check("core_arg1", core_arg1, e_a1);
          check("core_arg2", core_arg2, e_a2);
        end
        check("busy", 64'(busy), 64'(grant != 3'b0));
        if (done != 3'b0) begin
          check("done_vs_grant", 64'(done), 64'(grant));
          check("done_latency", 64'(cyc - gcyc), never_ready ? 64'd513 : 64'd41);
          check("done_terr", 64'(timeout_err), 64'(never_ready));
          check("done_core_en", 64'(core_enable), 0);
          e_res = never_ready ? 13'd0 : 13'(100 * (w_m + 1));
          rr_m = (w_m + 1) % 3;
          served.push_back(w_m);
        end else begin
          check("terr_idle", 64'(timeout_err), 0);
        end
        check("result", 64'(result), 64'(e_res));
        prev_grant = grant;
      end
    end
  end

  task automatic wait_grant(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant == 3'b0 && n < limit);
    check("grant_wait_bound", 64'(grant != 3'b0), 1);
  endtask

  task automatic wait_done(input int limit, output logic [2:0] d, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done == 3'b0 && n < limit);
    d = done;
    check("done_wait_bound", 64'(done != 3'b0), 1);
  endtask

  initial begin
    logic [2:0] d;
    int         n;
    int         cnt_done [3];
    int         exp_c [3];
    reset = 1'b1;
    req   = '0;
    for (int i = 0; i < 3; i++) begin
      arg1_flat[i*64 +: 64] = 64'h4000_0000_0000_0000 + 64'(i);
      arg2_flat[i*64 +: 64] = 64'h3FF0_0000_0000_0000 + 64'(i << 4);
    end
    repeat (3) @(negedge clk);
    check("reset_core_rst", 64'(core_reset), 1);
    check("reset_busy", 64'(busy), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Abort: req[0] dropped mid-run, pending req[2] then served.
    req = 3'b101;
    wait_grant(10, n);
    check("abort_first_grant", 64'(grant), 64'(3'b001));
    repeat (11) @(negedge clk);
    req = 3'b100;
    @(negedge clk);
    check("abort_core_rst", 64'(core_reset), 1);
    check("abort_busy", 64'(busy), 0);
    check("abort_no_done", 64'(done), 0);
    wait_grant(5, n);
    check("abort_next_grant", 64'(grant), 64'(3'b100));
    wait_done(100, d, n);
    check("req2_done", 64'(d), 64'(3'b100));
    check("req2_latency", 64'(n), 41);
    check("req2_result", 64'(result), 300);
    req = 3'b000;
    repeat (3) @(negedge clk);

    // Single request with operand change during service.
    req = 3'b010;
    @(negedge clk);
    check("single_grant", 64'(grant), 64'(3'b010));
    check("single_en_early", 64'(core_enable), 0);
    @(negedge clk);
    check("single_en", 64'(core_enable), 1);
    check("single_core_rst", 64'(core_reset), 0);
    arg1_flat[64 +: 64] = 64'h4000_0000_0000_0007;
    wait_done(100, d, n);
    check("single_done_at", 64'(n), 40);
    check("single_done", 64'(d), 64'(3'b010));
    check("single_result", 64'(result), 200);
    check("single_terr", 64'(timeout_err), 0);
    req = 3'b000;
    arg1_flat[64 +: 64] = 64'h4000_0000_0000_0001;
    repeat (3) @(negedge clk);
    check("single_result_held", 64'(result), 200);

    // Three simultaneous requests, each dropped after its done.
`ifdef ATAN_ARB_RR_EN
    exp_c = '{2, 0, 1};
`else
    exp_c = '{0, 1, 2};
`endif
    cnt_done = '{0, 0, 0};
    req = 3'b111;
    for (int s = 0; s < 3; s++) begin
      wait_done(200, d, n);
      for (int i = 0; i < 3; i++) if (d[i]) cnt_done[i]++;
      check("multi_order", 64'(d), 64'(3'b001 << exp_c[s]));
      check("multi_result", 64'(result), 64'(100 * (exp_c[s] + 1)));
      req = req & ~d;
    end
    for (int i = 0; i < 3; i++) check("multi_one_done", 64'(cnt_done[i]), 1);
    repeat (5) @(negedge clk);

    // req=011 held continuously across eight services.
    req = 3'b011;
    for (int s = 0; s < 8; s++) begin
      wait_done(200, d, n);
`ifdef ATAN_ARB_RR_EN
      check("hold_order", 64'(d), 64'(3'b001 << (s % 2)));
`else
      check("hold_order", 64'(d), 64'(3'b001));
`endif
      if (s == 7) req = 3'b000;
    end
    repeat (3) @(negedge clk);

    // Synchronous reset pulsed mid-run.
    req = 3'b010;
    wait_grant(10, n);
    repeat (12) @(negedge clk);
    reset = 1'b1;
    req   = 3'b000;
    @(negedge clk);
    check("midrst_grant", 64'(grant), 0);
    check("midrst_en", 64'(core_enable), 0);
    check("midrst_core_rst", 64'(core_reset), 1);
    check("midrst_busy", 64'(busy), 0);
    check("midrst_result", 64'(result), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Core never completes: timeout.
    never_ready = 1'b1;
    req = 3'b001;
    wait_grant(10, n);
    wait_done(600, d, n);
    check("to_latency", 64'(n), 513);
    check("to_done", 64'(d), 64'(3'b001));
    check("to_result", 64'(result), 0);
    check("to_terr", 64'(timeout_err), 1);
    req = 3'b000;
    @(negedge clk);
    check("to_terr_cleared", 64'(timeout_err), 0);
    never_ready = 1'b0;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
